rr_select_encoder: RTL and testbench
====================================

# rr_select_encoder

Parametrised, registered, round-robin multi-grant encoder for the out-of-order core's issue/select stage. It samples a request vector, picks up to NUM_GRANTS requesters in rotating-priority order, and presents their binary indices and a grant mask behind a valid/ready output register. A fairness pointer advances past the last grant. It is the successor to the fixed-width one-hot encoder: arbitrary width, multiple grants, tolerance of multiple active inputs, and state.

## Interface
- BIT_WIDTH, 16, number of request lines; any value 2..64.
- NUM_GRANTS, 2, maximum grants per transfer; 1..4, must be ≤ BIT_WIDTH.
- IDX_W (localparam), $clog2(BIT_WIDTH), index width.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  BIT_WIDTH  request vector; any number of bits may be set.
- out_ready  in  1  consumer accepts the current output.
- out_valid  out  1  at least one grant held in the output register.
- grant_valid  out  NUM_GRANTS  per-slot valid; contiguous from slot 0.
- grant_idx  out  NUM_GRANTS×IDX_W  binary index per slot; 0 when the slot is invalid.
- grant_mask  out  BIT_WIDTH  one-hot OR of all granted lines.

## Operation
- State: ptr (IDX_W bits, range 0..BIT_WIDTH-1) plus the output register.
- load = !out_valid || out_ready. When load is high, sample req and compute a new selection. When load is low, hold all outputs and ptr and ignore req.
- Selection order: ptr, ptr+1, …, BIT_WIDTH-1, 0, …, ptr-1.
  - Slot g receives the (g+1)-th set bit in that order.
  - Slots with no remaining set bit have grant_valid[g]=0 and grant_idx[g]=0.
- out_valid = grant_valid[0] of the loaded selection.
- ptr update on load with ≥1 grant: ptr ← (last valid grant index + 1), wrapping BIT_WIDTH-1 → 0. This holds for non-power-of-2 BIT_WIDTH.
- ptr update on load with zero grants: ptr unchanged, out_valid=0.
- Requesters are notified via grant_mask once out_valid && out_ready (fire). They must not assume a grant before fire.
- Elaboration: BIT_WIDTH<2, BIT_WIDTH>64, NUM_GRANTS<1, NUM_GRANTS>4 or NUM_GRANTS>BIT_WIDTH → $error.

## Timing
- Latency: req sampled at edge N appears on the outputs after edge N; one cycle.
- Throughput: one selection per cycle while out_ready=1.
- Reset values: out_valid=0, grant_valid=0, grant_idx=0, grant_mask=0, ptr=0.
- rst has priority over load. Asserting rst mid-stall discards the held grant with no fire.
- Simultaneous rst and out_ready: reset wins.
- out_ready while out_valid=0 has no effect beyond permitting load, which is always permitted then.
- No combinational path from req or out_ready to any output.

## Structure
- Package rr_select_pkg holds:
  - MAX_ENC_WIDTH=64 and MAX_GRANTS=4.
  - function rr_next_ptr(last_idx, width) for the wrap rule, shared with future select blocks.
- Sub-module onehot_to_bin #(BIT_WIDTH): a generic one-hot → binary encoder with no width limit, using OR-reduction per output bit. Instantiate one per grant slot on the slot's isolated one-hot vector.
- Rotation is implemented as a double-width concatenation of req, masked by ptr, with find-first-set repeated NUM_GRANTS times, each pass clearing the previous winner.

## Test plan
Configuration for all scenarios: BIT_WIDTH=8, NUM_GRANTS=2, out_ready=1 unless stated.
- Reset, then req=8'b1010_0110 → next cycle:
  - grant_idx={1,2}, grant_valid=2'b11, grant_mask=8'b0000_0110, ptr=3.
- Hold req=8'b1010_0110 → next selection:
  - grant_idx={5,7}, grant_mask=8'b1010_0000, ptr wraps to 0.
- Force ptr=7 via the prior grant, req=8'b1000_0001 → grant_idx={7,0}, ptr=1; checks wrap order.
- req=8'b0001_0000 → grant_valid=2'b01, grant_idx={4,0}, ptr=5.
- req=0 → out_valid=0 and ptr unchanged.
- Stall: out_valid=1 and out_ready=0 for 3 cycles while req toggles randomly → outputs and ptr constant. Raise out_ready → new selection from the current req appears one cycle later.
- rst pulsed during a stall with out_valid=1 → next cycle all outputs 0, ptr=0. The first post-reset req=8'b1111_1111 → grant_idx={0,1}.

Source files
------------

// File: rtl/rr_select_pkg.sv
// Shared constants and helpers for round-robin select blocks.
package rr_select_pkg;

   localparam int unsigned MAX_ENC_WIDTH = 64;
   localparam int unsigned MAX_GRANTS    = 4;

   // Pointer value one past the last grant, wrapping at width (any width, not just powers of 2).
   function automatic int unsigned rr_next_ptr(input int unsigned last_idx,
                                               input int unsigned width);
      return (last_idx + 1 >= width) ? 0 : last_idx + 1;
   endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// Generic one-hot to binary encoder; each output bit is the OR of the lines whose index has it set.
module onehot_to_bin #(
   parameter int unsigned BIT_WIDTH = 16,
   localparam int unsigned IDX_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1
) (
   input  logic [BIT_WIDTH-1:0] i_onehot,
   output logic [IDX_W-1:0]     o_bin
);

   for (genvar b = 0; b < IDX_W; b++) begin : g_bit
      logic [BIT_WIDTH-1:0] w_sel;
      for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_line
         localparam bit SEL = ((i >> b) & 1) == 1;
         assign w_sel[i] = SEL ? i_onehot[i] : 1'b0;
      end
      assign o_bin[b] = |w_sel;
   end

endmodule

// File: rtl/rr_select_encoder.sv
// Registered round-robin multi-grant encoder with valid/ready output and fairness pointer.
module rr_select_encoder
   import rr_select_pkg::*;
#(
   parameter int unsigned BIT_WIDTH  = 16,
   parameter int unsigned NUM_GRANTS = 2,
   localparam int unsigned IDX_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [BIT_WIDTH-1:0]        i_req,
   input  logic                        i_out_ready,
   output logic                        o_out_valid,
   output logic [NUM_GRANTS-1:0]       o_grant_valid,
   output logic [NUM_GRANTS*IDX_W-1:0] o_grant_idx,
   output logic [BIT_WIDTH-1:0]        o_grant_mask
);

   if (BIT_WIDTH < 2 || BIT_WIDTH > MAX_ENC_WIDTH || NUM_GRANTS < 1 ||
       NUM_GRANTS > MAX_GRANTS || NUM_GRANTS > BIT_WIDTH) begin : g_param_err
      $error("rr_select_encoder: illegal BIT_WIDTH/NUM_GRANTS combination");
   end

   logic [IDX_W-1:0]            r_ptr;
   logic                        r_out_valid;
   logic [NUM_GRANTS-1:0]       r_grant_valid;
   logic [NUM_GRANTS*IDX_W-1:0] r_grant_idx;
   logic [BIT_WIDTH-1:0]        r_grant_mask;

   logic                        w_load;
   logic [2*BIT_WIDTH-1:0]      w_window;
   logic [BIT_WIDTH-1:0]        w_slot_oh  [NUM_GRANTS];
   logic [IDX_W-1:0]            w_slot_idx [NUM_GRANTS];
   logic [NUM_GRANTS-1:0]       w_slot_v;
   logic [BIT_WIDTH-1:0]        w_mask;
   logic [NUM_GRANTS*IDX_W-1:0] w_idx_flat;
   logic [IDX_W-1:0]            w_last_idx;
   logic [IDX_W-1:0]            w_next_ptr;

   assign w_load = !r_out_valid || i_out_ready;

   // Window over {req, req}: exactly BIT_WIDTH positions starting at ptr, i.e. the rotated order.
   always_comb begin
      w_window = '0;
      for (int unsigned k = 0; k < 2 * BIT_WIDTH; k++) begin
         w_window[k] = (k >= 32'(r_ptr)) && (k < 32'(r_ptr) + BIT_WIDTH);
      end
   end

   // Repeated find-first-set over the window, clearing each winner before the next slot.
   always_comb begin
      logic [2*BIT_WIDTH-1:0] w_work;
      logic                   w_hit;
      w_work   = {i_req, i_req} & w_window;
      w_slot_v = '0;
      for (int g = 0; g < NUM_GRANTS; g++) begin
         w_slot_oh[g] = '0;
         w_hit        = 1'b0;
         for (int k = 0; k < BIT_WIDTH; k++) begin
            if (!w_hit && w_work[k]) begin
               w_hit           = 1'b1;
               w_work[k]       = 1'b0;
               w_slot_oh[g][k] = 1'b1;
            end
         end
         for (int k = 0; k < BIT_WIDTH; k++) begin
            if (!w_hit && w_work[k+BIT_WIDTH]) begin
               w_hit                 = 1'b1;
               w_work[k+BIT_WIDTH]   = 1'b0;
               w_slot_oh[g][k]       = 1'b1;
            end
         end
         w_slot_v[g] = w_hit;
      end
   end

   for (genvar g = 0; g < NUM_GRANTS; g++) begin : g_enc
      onehot_to_bin #(
         .BIT_WIDTH (BIT_WIDTH)
      ) u_enc (
         .i_onehot (w_slot_oh[g]),
         .o_bin    (w_slot_idx[g])
      );
   end

   // Merge slots into the flat index bus and mask; slots fill from 0 so the last valid is the last hit.
   always_comb begin
      w_mask     = '0;
      w_idx_flat = '0;
      w_last_idx = '0;
      for (int g = 0; g < NUM_GRANTS; g++) begin
         w_mask                       = w_mask | w_slot_oh[g];
         w_idx_flat[g*IDX_W +: IDX_W] = w_slot_idx[g];
         if (w_slot_v[g]) begin
            w_last_idx = w_slot_idx[g];
         end
      end
   end

   assign w_next_ptr = IDX_W'(rr_next_ptr(32'(w_last_idx), BIT_WIDTH));

   // Output register and pointer; reset wins over load, hold when stalled.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr         <= '0;
         r_out_valid   <= 1'b0;
         r_grant_valid <= '0;
         r_grant_idx   <= '0;
         r_grant_mask  <= '0;
      end else if (w_load) begin
         r_out_valid   <= w_slot_v[0];
         r_grant_valid <= w_slot_v;
         r_grant_idx   <= w_idx_flat;
         r_grant_mask  <= w_mask;
         if (w_slot_v[0]) begin
            r_ptr <= w_next_ptr;
         end
      end
   end

   assign o_out_valid   = r_out_valid;
   assign o_grant_valid = r_grant_valid;
   assign o_grant_idx   = r_grant_idx;
   assign o_grant_mask  = r_grant_mask;

endmodule

// File: tb/tb_rr_select_encoder.sv
// Self-checking bench: behavioural round-robin model plus hand-computed scenario checks.
module tb_rr_select_encoder;

   localparam int W  = 8;
   localparam int NG = 2;
   localparam int IW = 3;

   logic          clk;
   logic          rst;
   logic [W-1:0]  req;
   logic          ready;
   logic          out_valid;
   logic [NG-1:0] grant_valid;
   logic [NG*IW-1:0] grant_idx;
   logic [W-1:0]  grant_mask;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 0;

   // Model state
   logic             m_ov;
   logic [NG-1:0]    m_gv;
   logic [NG*IW-1:0] m_idx;
   logic [W-1:0]     m_mask;
   int               m_ptr;

   rr_select_encoder #(
      .BIT_WIDTH  (W),
      .NUM_GRANTS (NG)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_req         (req),
      .i_out_ready   (ready),
      .o_out_valid   (out_valid),
      .o_grant_valid (grant_valid),
      .o_grant_idx   (grant_idx),
      .o_grant_mask  (grant_mask)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: walk ptr, ptr+1, ... modulo W and hand out the first NG requesters found.
   always @(posedge clk) begin
      int cnt;
      int idx;
      int lastg;
      logic [W-1:0]     msk;
      logic [NG*IW-1:0] fidx;
      logic [NG-1:0]    gv;
      if (rst) begin
         m_ov <= 0; m_gv <= '0; m_idx <= '0; m_mask <= '0; m_ptr <= 0;
      end else if (!m_ov || ready) begin
         cnt = 0; msk = '0; fidx = '0; gv = '0; lastg = 0;
         for (int j = 0; j < W; j++) begin
            idx = (m_ptr + j) % W;
            if (req[idx] && cnt < NG) begin
               fidx[cnt*IW +: IW] = IW'(idx);
               gv[cnt]  = 1'b1;
               msk[idx] = 1'b1;
               lastg    = idx;
               cnt++;
            end
         end
         m_ov   <= (cnt > 0);
         m_gv   <= gv;
         m_idx  <= fidx;
         m_mask <= msk;
         if (cnt > 0) m_ptr <= (lastg + 1) % W;
      end
   end

   // Every-cycle comparison of DUT against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_out_valid", 64'(out_valid), 64'(m_ov));
         check("model_grant_valid", 64'(grant_valid), 64'(m_gv));
         check("model_grant_idx", 64'(grant_idx), 64'(m_idx));
         check("model_grant_mask", 64'(grant_mask), 64'(m_mask));
         check("model_ptr", 64'(dut.r_ptr), 64'(m_ptr));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic check_all(input string name, input logic ov, input logic [NG-1:0] gv,
                            input logic [NG*IW-1:0] gi, input logic [W-1:0] gm, input int p);
      check({name, "_out_valid"}, 64'(out_valid), 64'(ov));
      check({name, "_grant_valid"}, 64'(grant_valid), 64'(gv));
      check({name, "_grant_idx"}, 64'(grant_idx), 64'(gi));
      check({name, "_grant_mask"}, 64'(grant_mask), 64'(gm));
      check({name, "_ptr"}, 64'(dut.r_ptr), 64'(p));
   endtask

   initial begin
      rst = 1; req = '0; ready = 1;
      step();
      cmp_en = 1;
      step();
      rst = 0;
      check_all("reset", 1'b0, 2'b00, 6'd0, 8'h00, 0);

      // First selection after reset: {1,2}, ptr 3
      req = 8'b1010_0110;
      step();
      check_all("first", 1'b1, 2'b11, {3'd2, 3'd1}, 8'b0000_0110, 3);

      // Same request continues from ptr 3: {5,7}, ptr wraps to 0
      step();
      check_all("wrap_ptr", 1'b1, 2'b11, {3'd7, 3'd5}, 8'b1010_0000, 0);

      // Single grant on line 6 leaves ptr at 7
      req = 8'b0100_0000;
      step();
      check_all("ptr_to7", 1'b1, 2'b01, {3'd0, 3'd6}, 8'b0100_0000, 7);

      // From ptr 7 the order is 7 then 0
      req = 8'b1000_0001;
      step();
      check_all("wrap_order", 1'b1, 2'b11, {3'd0, 3'd7}, 8'b1000_0001, 1);

      // Only one requester
      req = 8'b0001_0000;
      step();
      check_all("single", 1'b1, 2'b01, {3'd0, 3'd4}, 8'b0001_0000, 5);

      // No requesters: nothing valid, ptr held
      req = 8'h00;
      step();
      check_all("empty", 1'b0, 2'b00, 6'd0, 8'h00, 5);

      // Load a grant from ptr 5, then stall it
      req = 8'b1010_0110;
      step();
      check_all("pre_stall", 1'b1, 2'b11, {3'd7, 3'd5}, 8'b1010_0000, 0);
      ready = 0;
      for (int i = 0; i < 3; i++) begin
         req = W'($urandom);
         step();
         check_all("stall_hold", 1'b1, 2'b11, {3'd7, 3'd5}, 8'b1010_0000, 0);
      end
      req = 8'b0001_1000;
      ready = 1;
      step();
      check_all("stall_release", 1'b1, 2'b11, {3'd4, 3'd3}, 8'b0001_1000, 5);

      // Reset during a stall discards the held grant
      ready = 0;
      req = 8'h0F;
      step();
      check_all("stall2_hold", 1'b1, 2'b11, {3'd4, 3'd3}, 8'b0001_1000, 5);
      rst = 1;
      step();
      rst = 0;
      check_all("rst_in_stall", 1'b0, 2'b00, 6'd0, 8'h00, 0);
      req = 8'hFF;
      ready = 1;
      step();
      check_all("post_rst", 1'b1, 2'b11, {3'd1, 3'd0}, 8'b0000_0011, 2);

      // Randomised traffic checked by the model on every cycle
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0:       req = '0;
            1:       req = W'(1 << $urandom_range(0, W - 1));
            default: req = W'($urandom);
         endcase
         ready = ($urandom_range(0, 9) < 7);
         rst   = ($urandom_range(0, 49) == 0);
         step();
      end
      rst = 0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
